// File: rtl/lzc_norm_arbiter.sv
// Two-requester round-robin front end sharing one 128-bit leading-zero count
// and normalize shifter, feeding a single registered output stage with backpressure.
module lzc_norm_arbiter #(
  parameter int TAG_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [127:0]     req0_data,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [127:0]     req1_data,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_id,
  output logic [TAG_W-1:0] out_tag,
  output logic [6:0]       out_count,
  output logic             out_zero,
  output logic [127:0]     out_data
);

  // Returns {any_one, leading_zero_count[5:0]} for a 64-bit slice.
  function automatic logic [6:0] lzc64(input logic [63:0] v);
    logic [6:0] r;
    r = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      if (v[i]) r = {1'b1, 6'(63 - i)};
    end
    return r;
  endfunction

  logic             ptr;
  logic             adv;
  logic             grant0;
  logic             grant1;
  logic [127:0]     sel_data;
  logic [TAG_W-1:0] sel_tag;
  logic [6:0]       hi_lzc;
  logic [6:0]       lo_lzc;
  logic [6:0]       cnt;
  logic             zero;
  logic [127:0]     norm;

  always_comb begin
    adv    = ~out_valid | out_ready;
    grant0 = adv & req0_valid & (~req1_valid | ~ptr);
    grant1 = adv & req1_valid & (~req0_valid |  ptr);
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;

  always_comb begin
    sel_data = grant1 ? req1_data : req0_data;
    sel_tag  = grant1 ? req1_tag  : req0_tag;
  end

  // Upper-half valid bit selects which half's count is used.
  always_comb begin
    hi_lzc = lzc64(sel_data[127:64]);
    lo_lzc = lzc64(sel_data[63:0]);
    cnt    = '0;
    if (hi_lzc[6])      cnt = {1'b0, hi_lzc[5:0]};
    else if (lo_lzc[6]) cnt = {1'b1, lo_lzc[5:0]};
    zero = ~(hi_lzc[6] | lo_lzc[6]);
    norm = sel_data << cnt;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_id    <= 1'b0;
      out_tag   <= '0;
      out_count <= '0;
      out_zero  <= 1'b0;
      out_data  <= '0;
      ptr       <= 1'b0;
    end else if (adv) begin
      if (grant0 | grant1) begin
        out_valid <= 1'b1;
        out_id    <= grant1;
        out_tag   <= sel_tag;
        out_count <= cnt;
        out_zero  <= zero;
        out_data  <= norm;
        ptr       <= ~grant1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lzc_norm_arbiter.sv
// Directed bench with an arbitration/count model and a result scoreboard queue.
module tb_lzc_norm_arbiter;

  localparam int TAG_W = 8;

  logic             clock = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic             req0_ready, req1_ready;
  logic [127:0]     req0_data, req1_data;
  logic [TAG_W-1:0] req0_tag, req1_tag;
  logic             out_valid, out_ready, out_id, out_zero;
  logic [TAG_W-1:0] out_tag;
  logic [6:0]       out_count;
  logic [127:0]     out_data;

  lzc_norm_arbiter #(.TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data), .req1_tag(req1_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id), .out_tag(out_tag),
    .out_count(out_count), .out_zero(out_zero), .out_data(out_data)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic             id;
    logic [TAG_W-1:0] tag;
    logic [6:0]       cnt;
    logic             zero;
    logic [127:0]     data;
  } res_t;

  res_t q[$];
  res_t last;
  res_t exp_r;
  logic m_ptr, m_ov, m_adv, m_g0, m_g1;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string name, input logic [127:0] obs, input logic [127:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", name, obs, expv);
    end
  endtask

  // Reference: scan from bit 127 downward.
  function automatic res_t model(input logic id, input logic [TAG_W-1:0] tag, input logic [127:0] d);
    res_t r;
    int   c;
    bit   found;
    c = 0;
    found = 0;
    for (int i = 127; i >= 0; i--) begin
      if (!found) begin
        if (d[i]) found = 1;
        else c++;
      end
    end
    if (!found) c = 0;
    r.id   = id;
    r.tag  = tag;
    r.cnt  = 7'(c);
    r.zero = !found;
    r.data = d << c;
    return r;
  endfunction

  function automatic logic [127:0] rnd128();
    logic [127:0] v;
    v = {$urandom, $urandom, $urandom, $urandom};
    return v >> $urandom_range(0, 127);
  endfunction

  task automatic cycle();
    #1;
    m_adv = !m_ov || out_ready;
    m_g0  = m_adv && req0_valid && (!req1_valid || !m_ptr);
    m_g1  = m_adv && req1_valid && (!req0_valid ||  m_ptr);
    if (!reset) begin
      chk("req0_ready", 128'(req0_ready), 128'(m_g0));
      chk("req1_ready", 128'(req1_ready), 128'(m_g1));
    end
    @(posedge clock);
    if (reset) begin
      q.delete();
      m_ov  = 0;
      m_ptr = 0;
      last  = '0;
    end else begin
      if (m_ov && out_ready && q.size() > 0) void'(q.pop_front());
      if (m_g0 || m_g1) begin
        last = m_g1 ? model(1'b1, req1_tag, req1_data) : model(1'b0, req0_tag, req0_data);
        q.push_back(last);
        m_ptr = !m_g1;
        m_ov  = 1;
      end else if (m_adv) begin
        m_ov = 0;
      end
    end
    #1;
    chk("out_valid", 128'(out_valid), 128'(m_ov));
    if (m_ov && q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL scoreboard_empty observed=%0d expected=1", q.size());
    end else begin
      exp_r = m_ov ? q[0] : last;
      chk("out_id",    128'(out_id),    128'(exp_r.id));
      chk("out_tag",   128'(out_tag),   128'(exp_r.tag));
      chk("out_count", 128'(out_count), 128'(exp_r.cnt));
      chk("out_zero",  128'(out_zero),  128'(exp_r.zero));
      chk("out_data",  out_data,        exp_r.data);
    end
  endtask

  task automatic drive(input logic v0, input logic [127:0] d0, input logic [TAG_W-1:0] t0,
                       input logic v1, input logic [127:0] d1, input logic [TAG_W-1:0] t1);
    req0_valid = v0; req0_data = d0; req0_tag = t0;
    req1_valid = v1; req1_data = d1; req1_tag = t1;
  endtask

  initial begin
    m_ptr = 0; m_ov = 0; last = '0;
    reset = 1; out_ready = 1;
    drive(0, '0, '0, 0, '0, '0);
    cycle(); cycle();
    reset = 0;

    // single op, bit 96 set
    drive(1, 128'h0000_0001_0000_0000_0000_0000_0000_0000, 8'h5A, 0, '0, '0);
    cycle();
    chk("bit96_count", 128'(out_count), 128'd31);
    chk("bit96_msb", 128'(out_data[127]), 128'd1);
    drive(0, '0, '0, 0, '0, '0);
    cycle();

    // zero operand, then MSB already set
    drive(0, '0, '0, 1, '0, 8'h11);
    cycle();
    chk("zero_flag", 128'(out_zero), 128'd1);
    drive(0, '0, '0, 1, 128'h8000_0000_0000_0000_0000_0000_0000_00F0, 8'h22);
    cycle();
    drive(0, '0, '0, 0, '0, '0);
    cycle();

    // bit 0 only, then MSB plus LSB
    drive(1, 128'd1, 8'h33, 0, '0, '0);
    cycle();
    chk("bit0_count", 128'(out_count), 128'd127);
    drive(1, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 8'h44, 0, '0, '0);
    cycle();

    // round robin with both valid
    for (int i = 0; i < 6; i++) begin
      drive(1, rnd128(), 8'(8'h60 + i), 1, rnd128(), 8'(8'h70 + i));
      cycle();
    end

    // backpressure with both valid, then release
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive(1, rnd128(), 8'(8'h80 + i), 1, rnd128(), 8'(8'h90 + i));
      cycle();
    end
    out_ready = 1;
    for (int i = 0; i < 3; i++) begin
      drive(1, rnd128(), 8'(8'hA0 + i), 1, rnd128(), 8'(8'hB0 + i));
      cycle();
    end

    // drain, then hold a req0 result so the pointer sits at 1
    drive(0, '0, '0, 0, '0, '0);
    cycle();
    out_ready = 0;
    drive(1, rnd128(), 8'hC0, 0, '0, '0);
    cycle();
    drive(1, rnd128(), 8'hC1, 1, rnd128(), 8'hC2);
    cycle();

    // mid-operation reset
    reset = 1;
    cycle();
    reset = 0;
    out_ready = 1;
    drive(1, rnd128(), 8'hD0, 1, rnd128(), 8'hD1);
    cycle();
    chk("post_reset_id", 128'(out_id), 128'd0);
    drive(1, rnd128(), 8'hD2, 1, rnd128(), 8'hD3);
    cycle();
    drive(0, '0, '0, 0, '0, '0);
    cycle();
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
